// File: rtl/treeval_engine.sv
// treeval_engine: message-driven tree evaluator. Nodes are loaded over the inbound
// message port, the tree is evaluated bottom-up one node per cycle, and the result is sent back.
module treeval_engine #(
   parameter int MAX_NODES = 64,
   parameter int W_MSG     = 64,
   parameter int W_REWARD  = 16,
   parameter int W_WEIGHT  = 10,
   parameter int W_FRAC    = 7,
   parameter int W_ACTION  = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_msg_rdy,
   input  logic [W_MSG-1:0] in_msg,
   output logic             in_msg_ack,
   output logic             out_msg_rdy,
   output logic [W_MSG-1:0] out_msg,
   input  logic             out_msg_ack
);

   localparam int W_ADDR = $clog2(MAX_NODES);
   localparam int W_N    = W_ADDR + 1;
   localparam int W_PROD = W_REWARD + W_WEIGHT + 1;
   localparam int W_CFG  = W_MSG - 4;

   localparam logic [1:0] CMD_RUN  = 2'd0;
   localparam logic [1:0] CMD_SET  = 2'd1;
   localparam logic [1:0] CMD_CFG  = 2'd2;
   localparam logic [1:0] CMD_READ = 2'd3;

   localparam logic [1:0] SUB_PARENT = 2'd0;
   localparam logic [1:0] SUB_STRAT  = 2'd1;
   localparam logic [1:0] SUB_REWARD = 2'd2;
   localparam logic [1:0] SUB_WEIGHT = 2'd3;
   localparam logic [1:0] CFG_NODES  = 2'd0;

   localparam logic [1:0] STRAT_MIN = 2'd0;
   localparam logic [1:0] STRAT_EXP = 2'd2;

   localparam logic signed [W_REWARD-1:0] VAL_MAX = {1'b0, {(W_REWARD-1){1'b1}}};
   localparam logic signed [W_REWARD-1:0] VAL_MIN = {1'b1, {(W_REWARD-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, ACK, CLEAR, EVAL, ROOT, RESP} state_t;

   function automatic logic signed [W_PROD-1:0] ext(input logic signed [W_REWARD-1:0] v);
      return {{(W_PROD-W_REWARD){v[W_REWARD-1]}}, v};
   endfunction

   // Clamp a wide intermediate to the reward range; overflow shows as disagreeing top bits.
   function automatic logic signed [W_REWARD-1:0] sat(input logic signed [W_PROD-1:0] x);
      if (x[W_PROD-1:W_REWARD-1] == '0 || x[W_PROD-1:W_REWARD-1] == '1)
         return x[W_REWARD-1:0];
      else
         return x[W_PROD-1] ? VAL_MIN : VAL_MAX;
   endfunction

   function automatic logic [W_MSG-1:0] err_msg(input logic [3:0] code);
      return {2'b11, {(W_MSG-6){1'b0}}, code};
   endfunction

   state_t state_reg, state_next;

   logic [W_MSG-1:0]           msg_reg;
   logic [W_ADDR-1:0]          idx_reg, idx_next;
   logic [W_N-1:0]             n_nodes_reg, n_nodes_next;
   logic [W_MSG-1:0]           resp_reg, resp_next;
   logic                       best_valid_reg, best_valid_next;
   logic signed [W_REWARD-1:0] best_c_reg, best_c_next;
   logic [W_ACTION-1:0]        best_act_reg, best_act_next;

   logic [W_ADDR-1:0]          parent_mem [MAX_NODES];
   logic signed [W_REWARD-1:0] reward_mem [MAX_NODES];
   logic [W_WEIGHT-1:0]        weight_mem [MAX_NODES];
   logic [1:0]                 strat_mem  [MAX_NODES];
   logic [W_ACTION-1:0]        action_mem [MAX_NODES];
   logic signed [W_REWARD-1:0] value_mem  [MAX_NODES];
   logic signed [W_REWARD-1:0] acc_mem    [MAX_NODES];
   logic [MAX_NODES-1:0]       has_child_reg;

   logic set_we, clr_we, eval_we, root_we;

   logic [1:0]        cmd, node_sub, cfg_sub;
   logic [W_ADDR-1:0] node_idx;
   logic [W_CFG-1:0]  cfg_val;
   logic              idx_bad, cfg_bad;

   assign cmd      = msg_reg[W_MSG-1 -: 2];
   assign node_idx = msg_reg[W_MSG-3 -: W_ADDR];
   assign node_sub = msg_reg[W_MSG-3-W_ADDR -: 2];
   assign cfg_sub  = msg_reg[W_MSG-3 -: 2];
   assign cfg_val  = msg_reg[W_CFG-1:0];
   assign idx_bad  = ({1'b0, node_idx} >= n_nodes_reg);
   assign cfg_bad  = (cfg_val == '0) || (cfg_val > W_CFG'(MAX_NODES));

   // Datapath for the node under the cursor and its parent's accumulator.
   logic [W_ADDR-1:0]          cur_parent;
   logic signed [W_REWARD-1:0] cur_val, cur_c, acc_upd, clr_init;
   logic signed [W_PROD-1:0]   prod;
   logic                       better;

   assign cur_parent = parent_mem[idx_reg];

   always_comb begin
      cur_val = has_child_reg[idx_reg] ? sat(ext(reward_mem[idx_reg]) + ext(acc_mem[idx_reg]))
                                       : reward_mem[idx_reg];
      prod    = ext(cur_val) * $signed({{(W_PROD-W_WEIGHT){1'b0}}, weight_mem[idx_reg]});
      cur_c   = sat(prod >>> W_FRAC);
      case (strat_mem[cur_parent])
         STRAT_MIN: acc_upd = (cur_c < acc_mem[cur_parent]) ? cur_c : acc_mem[cur_parent];
         STRAT_EXP: acc_upd = sat(ext(acc_mem[cur_parent]) + ext(cur_c));
         default:   acc_upd = (cur_c > acc_mem[cur_parent]) ? cur_c : acc_mem[cur_parent];
      endcase
      case (strat_mem[idx_reg])
         STRAT_MIN: clr_init = VAL_MAX;
         STRAT_EXP: clr_init = '0;
         default:   clr_init = VAL_MIN;
      endcase
      // Strict comparison so that on ties the first visited (higher index) child wins.
      better = !best_valid_reg ||
               ((strat_mem[0] == STRAT_MIN) ? (cur_c < best_c_reg) : (cur_c > best_c_reg));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next      = state_reg;
      idx_next        = idx_reg;
      n_nodes_next    = n_nodes_reg;
      resp_next       = resp_reg;
      best_valid_next = best_valid_reg;
      best_c_next     = best_c_reg;
      best_act_next   = best_act_reg;
      set_we          = 1'b0;
      clr_we          = 1'b0;
      eval_we         = 1'b0;
      root_we         = 1'b0;
      in_msg_ack      = (state_reg == ACK);
      out_msg_rdy     = (state_reg == RESP);
      out_msg         = (state_reg == RESP) ? resp_reg : '0;
      case (state_reg)
         IDLE: if (in_msg_rdy) state_next = ACK;
         ACK: begin
            case (cmd)
               CMD_RUN: begin
                  state_next      = CLEAR;
                  idx_next        = '0;
                  best_valid_next = 1'b0;
               end
               CMD_SET: begin
                  if (idx_bad) begin
                     resp_next  = err_msg(4'd1);
                     state_next = RESP;
                  end else begin
                     set_we     = 1'b1;
                     state_next = IDLE;
                  end
               end
               CMD_CFG: begin
                  if (cfg_sub == CFG_NODES && cfg_bad) begin
                     resp_next  = err_msg(4'd3);
                     state_next = RESP;
                  end else begin
                     if (cfg_sub == CFG_NODES) n_nodes_next = cfg_val[W_N-1:0];
                     state_next = IDLE;
                  end
               end
               default: begin
                  resp_next  = idx_bad ? err_msg(4'd1)
                                       : {2'b01, {(W_MSG-2-W_REWARD){1'b0}}, value_mem[node_idx]};
                  state_next = RESP;
               end
            endcase
         end
         CLEAR: begin
            clr_we = 1'b1;
            // The cursor stops on n-1, which is where EVAL starts (or 0 when n is 1).
            if ({1'b0, idx_reg} == n_nodes_reg - W_N'(1))
               state_next = (n_nodes_reg == W_N'(1)) ? ROOT : EVAL;
            else
               idx_next = idx_reg + W_ADDR'(1);
         end
         EVAL: begin
            if (cur_parent >= idx_reg) begin
               resp_next  = err_msg(4'd2);
               state_next = RESP;
            end else begin
               eval_we = 1'b1;
               if (cur_parent == '0 && better) begin
                  best_valid_next = 1'b1;
                  best_c_next     = cur_c;
                  best_act_next   = action_mem[idx_reg];
               end
               if (idx_reg == W_ADDR'(1)) begin
                  idx_next   = '0;
                  state_next = ROOT;
               end else begin
                  idx_next = idx_reg - W_ADDR'(1);
               end
            end
         end
         ROOT: begin
            root_we    = 1'b1;
            resp_next  = {2'b00, {(W_MSG-2-W_ACTION-W_REWARD){1'b0}},
                          best_valid_reg ? best_act_reg : action_mem[0], cur_val};
            state_next = RESP;
         end
         RESP: if (out_msg_ack) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         msg_reg        <= '0;
         idx_reg        <= '0;
         n_nodes_reg    <= W_N'(1);
         resp_reg       <= '0;
         best_valid_reg <= 1'b0;
         best_c_reg     <= '0;
         best_act_reg   <= '0;
         has_child_reg  <= '0;
         for (int i = 0; i < MAX_NODES; i++) begin
            parent_mem[i] <= '0;
            reward_mem[i] <= '0;
            weight_mem[i] <= '0;
            strat_mem[i]  <= STRAT_MIN;
            action_mem[i] <= '0;
            value_mem[i]  <= '0;
            acc_mem[i]    <= '0;
         end
      end else begin
         if (state_reg == IDLE && in_msg_rdy) msg_reg <= in_msg;
         idx_reg        <= idx_next;
         n_nodes_reg    <= n_nodes_next;
         resp_reg       <= resp_next;
         best_valid_reg <= best_valid_next;
         best_c_reg     <= best_c_next;
         best_act_reg   <= best_act_next;
         if (set_we) begin
            case (node_sub)
               SUB_PARENT: parent_mem[node_idx] <= msg_reg[W_ADDR-1:0];
               SUB_STRAT: begin
                  strat_mem[node_idx]  <= msg_reg[W_ACTION+1:W_ACTION];
                  action_mem[node_idx] <= msg_reg[W_ACTION-1:0];
               end
               SUB_REWARD: reward_mem[node_idx] <= msg_reg[W_REWARD-1:0];
               SUB_WEIGHT: weight_mem[node_idx] <= msg_reg[W_WEIGHT-1:0];
               default: ;
            endcase
         end
         if (clr_we) begin
            acc_mem[idx_reg]       <= clr_init;
            has_child_reg[idx_reg] <= 1'b0;
         end
         if (eval_we) begin
            value_mem[idx_reg]        <= cur_val;
            acc_mem[cur_parent]       <= acc_upd;
            has_child_reg[cur_parent] <= 1'b1;
         end
         if (root_we) value_mem[0] <= cur_val;
      end
   end

endmodule

// File: tb/tb_treeval_engine.sv
// tb_treeval_engine: directed and randomized checks of treeval_engine against a
// child-list reference model of the tree evaluation rules.
module tb_treeval_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_msg_rdy;
   logic [63:0] in_msg;
   logic        in_msg_ack;
   logic        out_msg_rdy;
   logic [63:0] out_msg;
   logic        out_msg_ack;

   treeval_engine dut (
      .clk         (clk),
      .rst         (rst),
      .in_msg_rdy  (in_msg_rdy),
      .in_msg      (in_msg),
      .in_msg_ack  (in_msg_ack),
      .out_msg_rdy (out_msg_rdy),
      .out_msg     (out_msg),
      .out_msg_ack (out_msg_ack)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: node store plus per-node values of the last completed run.
   int m_n;
   int m_par[64], m_rew[64], m_wt[64], m_str[64], m_act[64], m_val[64];

   task automatic model_reset();
      m_n = 1;
      for (int i = 0; i < 64; i++) begin
         m_par[i] = 0; m_rew[i] = 0; m_wt[i] = 0; m_str[i] = 0; m_act[i] = 0; m_val[i] = 0;
      end
   endtask

   function automatic int sat16(input longint x);
      if (x > 32767)  return 32767;
      if (x < -32768) return -32768;
      return int'(x);
   endfunction

   function automatic logic [63:0] mk_result(input int a, input int v);
      logic [63:0] m;
      m = '0;
      m[18:16] = a[2:0];
      m[15:0]  = v[15:0];
      return m;
   endfunction

   function automatic logic [63:0] mk_read(input int v);
      logic [63:0] m;
      m = '0;
      m[63:62] = 2'b01;
      m[15:0]  = v[15:0];
      return m;
   endfunction

   function automatic logic [63:0] mk_err(input int code);
      logic [63:0] m;
      m = '0;
      m[63:62] = 2'b11;
      m[3:0]   = code[3:0];
      return m;
   endfunction

   function automatic logic [63:0] mk_node(input int cmd, input int idx, input int sub, input int data);
      logic [63:0] m;
      m = '0;
      m[63:62] = cmd[1:0];
      m[61:56] = idx[5:0];
      m[55:54] = sub[1:0];
      m[15:0]  = data[15:0];
      return m;
   endfunction

   function automatic logic [63:0] mk_cfg(input int val);
      logic [63:0] m;
      m = '0;
      m[63:62] = 2'b10;
      m[31:0]  = val;
      return m;
   endfunction

   // Each node folds over its own children (visited from the highest index down).
   function automatic logic [63:0] model_run(output bit is_err);
      int c[64];
      logic [63:0] res;
      is_err = 1'b0;
      res = '0;
      for (int i = 1; i < m_n; i++)
         if (m_par[i] >= i) begin
            is_err = 1'b1;
            return mk_err(2);
         end
      for (int i = m_n - 1; i >= 0; i--) begin
         int acc; bit has; int best_c; int best_a; int v;
         acc = 0; has = 1'b0; best_c = 0; best_a = m_act[i];
         for (int j = m_n - 1; j > i; j--) begin
            if (m_par[j] == i) begin
               if (!has) acc = c[j];
               else if (m_str[i] == 0) acc = (c[j] < acc) ? c[j] : acc;
               else if (m_str[i] == 2) acc = sat16(longint'(acc) + c[j]);
               else acc = (c[j] > acc) ? c[j] : acc;
               if (i == 0 && (!has || (m_str[0] == 0 ? c[j] < best_c : c[j] > best_c))) begin
                  best_c = c[j];
                  best_a = m_act[j];
               end
               has = 1'b1;
            end
         end
         v = has ? sat16(longint'(m_rew[i]) + acc) : m_rew[i];
         m_val[i] = v;
         c[i] = sat16((longint'(v) * m_wt[i]) >>> 7);
         if (i == 0) res = mk_result(best_a, v);
      end
      return res;
   endfunction

   task automatic send(input logic [63:0] m, output int ack_cyc);
      in_msg     = m;
      in_msg_rdy = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (in_msg_ack) break;
      end
      if (!in_msg_ack) check("ack_timeout", {63'b0, in_msg_ack}, 64'd1);
      ack_cyc    = cyc;
      in_msg_rdy = 1'b0;
      in_msg     = '0;
      @(negedge clk);
      check("ack_pulse", {63'b0, in_msg_ack}, 64'd0);
   endtask

   task automatic recv(input string tag, input int ack_cyc, input int lat,
                       input logic [63:0] exp, output logic [63:0] got);
      for (int k = 0; k < 400 && !out_msg_rdy; k++) @(negedge clk);
      got = out_msg;
      if (!out_msg_rdy) begin
         check({tag, "_timeout"}, {63'b0, out_msg_rdy}, 64'd1);
      end else begin
         check(tag, out_msg, exp);
         if (lat > 0) check({tag, "_lat"}, 64'(cyc - ack_cyc), 64'(lat));
         out_msg_ack = 1'b1;
         @(negedge clk);
         out_msg_ack = 1'b0;
         check({tag, "_drop"}, {out_msg_rdy, out_msg[62:0]} | {63'b0, out_msg[63]}, 64'd0);
      end
   endtask

   task automatic set_node(input int i, input int sub, input int data);
      int a;
      logic [63:0] g;
      send(mk_node(1, i, sub, data), a);
      if (i >= m_n) begin
         recv("set_idx_err", a, 0, mk_err(1), g);
      end else begin
         check("set_noresp", {63'b0, out_msg_rdy}, 64'd0);
         case (sub)
            0: m_par[i] = data & 63;
            1: begin m_str[i] = (data >> 3) & 3; m_act[i] = data & 7; end
            2: m_rew[i] = int'($signed(data[15:0]));
            default: m_wt[i] = data & 1023;
         endcase
      end
   endtask

   task automatic load_node(input int i, input int par, input int str, input int act,
                            input int rew, input int wt);
      set_node(i, 0, par);
      set_node(i, 1, (str << 3) | act);
      set_node(i, 2, rew & 16'hFFFF);
      set_node(i, 3, wt);
   endtask

   task automatic set_n(input int n);
      int a;
      logic [63:0] g;
      send(mk_cfg(n), a);
      if (n == 0 || n > 64) begin
         recv("cfg_err", a, 0, mk_err(3), g);
      end else begin
         check("cfg_noresp", {63'b0, out_msg_rdy}, 64'd0);
         m_n = n;
      end
   endtask

   task automatic run_expect(input string tag, output logic [63:0] got);
      bit e;
      int a;
      logic [63:0] exp;
      exp = model_run(e);
      send(64'd0, a);
      recv(tag, a, e ? 0 : 2 * m_n + 1, exp, got);
   endtask

   task automatic read_expect(input string tag, input int idx);
      int a;
      logic [63:0] g;
      send(mk_node(3, idx, 0, 0), a);
      recv(tag, a, 0, (idx >= m_n) ? mk_err(1) : mk_read(m_val[idx]), g);
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      #1;
      check("rst_ack", {63'b0, in_msg_ack}, 64'd0);
      check("rst_rdy", {63'b0, out_msg_rdy}, 64'd0);
      check("rst_msg", out_msg, 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      logic [63:0] got, held;
      int a, seen;
      bit e;
      rst = 1'b1; in_msg_rdy = 1'b0; in_msg = '0; out_msg_ack = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check("reset_ack", {63'b0, in_msg_ack}, 64'd0);
      check("reset_rdy", {63'b0, out_msg_rdy}, 64'd0);
      check("reset_msg", out_msg, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      read_expect("read_before_run", 0);

      // Three-node tree under each root strategy.
      set_n(3);
      load_node(0, 0, 1, 0, 0, 0);
      load_node(1, 0, 0, 1, 40, 128);
      load_node(2, 0, 0, 2, 100, 64);
      run_expect("run_max", got);
      check("run_max_spec", got, mk_result(2, 50));
      read_expect("read_idx2", 2);
      set_node(0, 1, (0 << 3) | 0);
      run_expect("run_min", got);
      check("run_min_spec", got, mk_result(1, 40));
      set_node(0, 1, (2 << 3) | 0);
      run_expect("run_exp", got);
      check("run_exp_spec", got, mk_result(2, 90));

      // Two levels with saturation in both directions.
      set_n(4);
      load_node(0, 0, 1, 0, 0, 0);
      load_node(1, 0, 1, 1, 0, 128);
      load_node(2, 1, 0, 2, -30000, 256);
      load_node(3, 1, 0, 3, 30000, 256);
      run_expect("run_sat_pos", got);
      check("run_sat_pos_spec", got[15:0], 64'd32767);
      set_node(3, 2, -30000 & 16'hFFFF);
      run_expect("run_sat_neg", got);
      check("run_sat_neg_spec", got[15:0], 64'h8000);

      // Error responses, each followed by a good run.
      set_n(3);
      load_node(0, 0, 1, 0, 0, 0);
      load_node(1, 0, 0, 1, 40, 128);
      load_node(2, 0, 0, 2, 100, 64);
      set_node(5, 2, 7);
      run_expect("run_after_e1", got);
      set_node(2, 0, 2);
      run_expect("run_bad_parent", got);
      check("run_bad_parent_spec", got, mk_err(2));
      set_node(2, 0, 0);
      run_expect("run_after_e2", got);
      set_n(0);
      set_n(65);
      run_expect("run_after_e3", got);
      check("run_after_e3_spec", got, mk_result(2, 50));
      read_expect("read_oob", 3);

      // Response held by the receiver: output stable, new message waits.
      e = 1'b0;
      held = model_run(e);
      send(64'd0, a);
      for (int k = 0; k < 50 && !out_msg_rdy; k++) @(negedge clk);
      check("hold_first", out_msg, held);
      in_msg = mk_node(3, 1, 0, 0);
      in_msg_rdy = 1'b1;
      seen = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (out_msg !== held || !out_msg_rdy || in_msg_ack) seen++;
      end
      check("hold_stable", 64'(seen), 64'd0);
      out_msg_ack = 1'b1;
      @(negedge clk);
      out_msg_ack = 1'b0;
      for (int k = 0; k < 10 && !in_msg_ack; k++) @(negedge clk);
      check("hold_late_ack", {63'b0, in_msg_ack}, 64'd1);
      in_msg_rdy = 1'b0;
      in_msg = '0;
      recv("hold_read", cyc, 0, mk_read(m_val[1]), got);

      // Randomized trees.
      for (int it = 0; it < 20; it++) begin
         int n;
         n = $urandom_range(1, 10);
         set_n(n);
         for (int i = 0; i < n; i++)
            load_node(i, (i == 0) ? 0 : $urandom_range(0, i - 1), $urandom_range(0, 3),
                      $urandom_range(0, 7),
                      ($urandom_range(0, 2) == 0) ? $urandom_range(0, 65535) - 32768
                                                  : $urandom_range(0, 400) - 200,
                      $urandom_range(0, 1023));
         run_expect($sformatf("rand_run%0d", it), got);
         read_expect($sformatf("rand_read%0d", it), $urandom_range(0, n));
      end

      // Reset during EVAL: no response afterwards, store back to defaults.
      set_n(8);
      for (int i = 0; i < 8; i++)
         load_node(i, (i == 0) ? 0 : i - 1, 1, i, 10 * i, 128);
      send(64'd0, a);
      repeat (9) @(negedge clk);
      reset_pulse();
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (out_msg_rdy) seen++;
      end
      check("no_resp_after_rst", 64'(seen), 64'd0);
      read_expect("read_after_rst", 0);
      read_expect("read_oob_after_rst", 1);
      run_expect("run_after_rst", got);
      check("run_after_rst_spec", got, mk_result(0, 0));

      // Reset while a response is on the port drops it immediately.
      send(64'd0, a);
      for (int k = 0; k < 50 && !out_msg_rdy; k++) @(negedge clk);
      check("resp_before_rst", {63'b0, out_msg_rdy}, 64'd1);
      reset_pulse();
      run_expect("run_after_rst2", got);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
